// File: rtl/voice_scheduler.sv
// Round-robin scheduler for three voices: snapshots the register bank on each sample tick,
// drives one generator request per voice and sums the gated samples. Define VOICE_SCHED_WATCHDOG_EN to add a WAIT-state watchdog.
module voice_scheduler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sample_tick_i,
    input  logic        reg_we_i,
    input  logic [3:0]  reg_addr_i,
    input  logic [7:0]  reg_wdata_i,
    output logic        start_o,
    output logic [1:0]  act_voice_o,
    output logic [15:0] freq_word_o,
    output logic [11:0] pw_word_o,
    output logic [3:0]  wave_sel_o,
    input  logic        ready_i,
    input  logic [9:0]  wave_i,
    output logic [11:0] mix_o,
    output logic        mix_valid_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  voice_reg;
    logic [11:0] acc_reg, mix_reg;
    logic        mix_valid_reg, overrun_reg;
    logic        accept, ready_ok, voice_gate;

    logic [15:0] sh_freq [3];
    logic [11:0] sh_pw   [3];
    logic [3:0]  sh_ws   [3];
    logic        sh_gate [3];

    assign accept   = (state_reg == IDLE) && sample_tick_i;
    assign ready_ok = (state_reg == WAIT) && ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_voice
            localparam logic [3:0] BASE = 4'(5 * gi);
            logic [15:0] freq_reg, sh_freq_reg;
            logic [11:0] pw_reg, sh_pw_reg;
            logic [3:0]  ws_reg, sh_ws_reg;
            logic        gate_reg, sh_gate_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    freq_reg    <= '0;
                    pw_reg      <= '0;
                    ws_reg      <= '0;
                    gate_reg    <= 1'b0;
                    sh_freq_reg <= '0;
                    sh_pw_reg   <= '0;
                    sh_ws_reg   <= '0;
                    sh_gate_reg <= 1'b0;
                end else begin
                    if (reg_we_i) begin
                        if (reg_addr_i == BASE)         freq_reg[7:0]  <= reg_wdata_i;
                        if (reg_addr_i == BASE + 4'd1)  freq_reg[15:8] <= reg_wdata_i;
                        if (reg_addr_i == BASE + 4'd2)  pw_reg[7:0]    <= reg_wdata_i;
                        if (reg_addr_i == BASE + 4'd3)  pw_reg[11:8]   <= reg_wdata_i[3:0];
                        if (reg_addr_i == BASE + 4'd4) begin
                            ws_reg   <= reg_wdata_i[7:4];
                            gate_reg <= reg_wdata_i[0];
                        end
                    end
                    // Snapshot sees the pre-edge live values, so a write coinciding with the tick lands next frame.
                    if (accept) begin
                        sh_freq_reg <= freq_reg;
                        sh_pw_reg   <= pw_reg;
                        sh_ws_reg   <= ws_reg;
                        sh_gate_reg <= gate_reg;
                    end
                end
            end

            assign sh_freq[gi] = sh_freq_reg;
            assign sh_pw[gi]   = sh_pw_reg;
            assign sh_ws[gi]   = sh_ws_reg;
            assign sh_gate[gi] = sh_gate_reg;
        end
    endgenerate

    always_comb begin
        freq_word_o = sh_freq[0];
        pw_word_o   = sh_pw[0];
        wave_sel_o  = sh_ws[0];
        voice_gate  = sh_gate[0];
        if (voice_reg == 2'd1) begin
            freq_word_o = sh_freq[1];
            pw_word_o   = sh_pw[1];
            wave_sel_o  = sh_ws[1];
            voice_gate  = sh_gate[1];
        end else if (voice_reg == 2'd2) begin
            freq_word_o = sh_freq[2];
            pw_word_o   = sh_pw[2];
            wave_sel_o  = sh_ws[2];
            voice_gate  = sh_gate[2];
        end
    end

`ifdef VOICE_SCHED_WATCHDOG_EN
    logic [3:0] wd_cnt_reg;
    logic       wd_expire, timeout_reg;

    assign wd_expire = (state_reg == WAIT) && !ready_i && (wd_cnt_reg == 4'd14);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wd_expire;
            if ((state_reg == WAIT) && !ready_i) wd_cnt_reg <= wd_cnt_reg + 4'd1;
            else                                 wd_cnt_reg <= '0;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_o    = 1'b0;
        busy_o     = (state_reg != IDLE);
        case (state_reg)
            IDLE:  if (sample_tick_i) state_next = START;
            START: begin
                start_o    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (ready_i) begin
                    state_next = (voice_reg == 2'd2) ? DONE : START;
                end
`ifdef VOICE_SCHED_WATCHDOG_EN
                else if (wd_expire) begin
                    state_next = IDLE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            voice_reg     <= '0;
            acc_reg       <= '0;
            mix_reg       <= '0;
            mix_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            mix_valid_reg <= (state_reg == DONE);
            overrun_reg   <= sample_tick_i && (state_reg != IDLE);
            if (accept) begin
                voice_reg <= '0;
                acc_reg   <= '0;
            end else if (ready_ok) begin
                // Ungated voices still run so their phase keeps advancing; they just contribute zero.
                acc_reg <= acc_reg + (voice_gate ? {2'b00, wave_i} : 12'd0);
                if (voice_reg != 2'd2) voice_reg <= voice_reg + 2'd1;
            end
            if (state_reg == DONE) mix_reg <= acc_reg;
        end
    end

    assign act_voice_o = voice_reg;
    assign mix_o       = mix_reg;
    assign mix_valid_o = mix_valid_reg;
    assign overrun_o   = overrun_reg;
endmodule
